// File: rtl/mat_mult_ctrl_if.sv
// Operand stream, result stream and engine connection for mat_mult_ctrl.
// slave is the controller side; master is the side that feeds operands,
// consumes results and models the multiply engine.
interface mat_mult_ctrl_if #(
  parameter int N_ROWS    = 2,
  parameter int N_COLUMNS = 2
);
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic signed [31:0] eng_mat1    [N_ROWS][N_COLUMNS];
  logic signed [31:0] eng_mat2    [N_ROWS][N_COLUMNS];
  logic               eng_enable;
  logic               eng_mult_done;
  logic signed [31:0] eng_mat_out [N_ROWS][N_COLUMNS];
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               busy;
  logic               timeout_err;

  modport slave (
    input  start, in_valid, in_data, eng_mult_done, eng_mat_out, out_ready,
    output in_ready, eng_mat1, eng_mat2, eng_enable, out_valid, out_data,
           busy, timeout_err
  );

  modport master (
    output start, in_valid, in_data, eng_mult_done, eng_mat_out, out_ready,
    input  in_ready, eng_mat1, eng_mat2, eng_enable, out_valid, out_data,
           busy, timeout_err
  );
endinterface

// File: rtl/mat_mult_ctrl.sv
// Matrix-multiply sequencer: streams in A (row-major) and B (column per row),
// runs the external engine with a cycle-count abort, then streams the result
// out row-major.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_LOAD_A  | accepting N_ROWS*N_COLUMNS elements into eng_mat1
// S_LOAD_B  | accepting N_ROWS*N_COLUMNS elements into eng_mat2
// S_COMPUTE | engine enabled; wait for done or abort on timeout
// S_DRAIN   | presenting result register on out_data
module mat_mult_ctrl #(
  parameter int N_ROWS         = 2,
  parameter int N_COLUMNS      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  mat_mult_ctrl_if.slave  bus
);
  localparam int NE = N_ROWS * N_COLUMNS;
  localparam int CW = $clog2(NE + 1);
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [TW-1:0]      r_tcnt;
  logic               r_timeout_err;
  logic signed [31:0] r_mat1 [NE];
  logic signed [31:0] r_mat2 [NE];
  logic signed [31:0] r_res  [NE];

  logic [IW-1:0]      w_idx;
  logic               w_last;
  logic               w_done;
  logic               w_tmo;
  logic               w_in_hs;
  logic               w_out_hs;

  // Counter never holds NE: it returns to 0 on the final element, so the low
  // bits are always a valid flat index.
  assign w_idx    = r_cnt[IW-1:0];
  assign w_last   = (r_cnt == CW'(NE - 1));
  // Done is not trusted on the first COMPUTE cycle (engine still sees old enable).
  assign w_done   = (r_state == S_COMPUTE) && bus.eng_mult_done && (r_tcnt != '0);
  assign w_tmo    = (r_state == S_COMPUTE) && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_in_hs  = bus.in_valid && bus.in_ready;
  assign w_out_hs = bus.out_valid && bus.out_ready;

  assign bus.timeout_err = r_timeout_err;

  for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < N_COLUMNS; gj++) begin : g_col
      assign bus.eng_mat1[gi][gj] = r_mat1[gi * N_COLUMNS + gj];
      assign bus.eng_mat2[gi][gj] = r_mat2[gi * N_COLUMNS + gj];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; done takes priority over timeout on the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.start)          w_next = S_LOAD_A;
      S_LOAD_A:  if (w_in_hs && w_last)  w_next = S_LOAD_B;
      S_LOAD_B:  if (w_in_hs && w_last)  w_next = S_COMPUTE;
      S_COMPUTE: if (w_done)             w_next = S_DRAIN;
                 else if (w_tmo)         w_next = S_IDLE;
      S_DRAIN:   if (w_out_hs && w_last) w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  // Output decode; out_data is forced to 0 outside DRAIN.
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.eng_enable = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = '0;
    bus.busy       = (r_state != S_IDLE);
    case (r_state)
      S_LOAD_A, S_LOAD_B: bus.in_ready = 1'b1;
      S_COMPUTE:          bus.eng_enable = 1'b1;
      S_DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_res[w_idx];
      end
      default: ;
    endcase
  end

  // Element/timeout counters, operand and result registers, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
      for (int k = 0; k < NE; k++) begin
        r_mat1[IW'(k)] <= '0;
        r_mat2[IW'(k)] <= '0;
        r_res[IW'(k)]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_tcnt <= '0;
          if (bus.start) r_timeout_err <= 1'b0;
        end
        S_LOAD_A: if (w_in_hs) begin
          r_mat1[w_idx] <= bus.in_data;
          r_cnt         <= w_last ? '0 : r_cnt + CW'(1);
        end
        S_LOAD_B: begin
          r_tcnt <= '0;
          if (w_in_hs) begin
            r_mat2[w_idx] <= bus.in_data;
            r_cnt         <= w_last ? '0 : r_cnt + CW'(1);
          end
        end
        S_COMPUTE: begin
          r_tcnt <= r_tcnt + TW'(1);
          if (w_done) begin
            r_cnt <= '0;
            for (int i = 0; i < N_ROWS; i++)
              for (int j = 0; j < N_COLUMNS; j++)
                r_res[IW'(i * N_COLUMNS + j)] <= bus.eng_mat_out[i][j];
          end else if (w_tmo) begin
            r_timeout_err <= 1'b1;
          end
        end
        S_DRAIN: if (w_out_hs) r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        default: ;
      endcase
    end
  end
endmodule
